// File: rtl/bip_result_receiver.sv
// Host-side BIP result link: 8N1 UART receiver feeding a 3-byte
// frame assembler (inst_count, accumulator high, accumulator low).
module bip_result_receiver #(
  parameter int DATA_BITS     = 8,
  parameter int OVERSAMPLE    = 16,
  parameter int TIMEOUT_TICKS = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_baud_rate,
  input  logic                     i_rx,
  output logic [DATA_BITS-1:0]     o_inst_count,
  output logic [2*DATA_BITS-1:0]   o_accumulator,
  output logic                     o_result_valid,
  output logic                     o_frame_error,
  output logic                     o_timeout,
  output logic                     o_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam int CW = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_TICKS - 1);
  localparam logic [CW-1:0] TO_MAX    = CW'(TIMEOUT_TICKS);

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    A_INST, A_ACC_HIGH, A_ACC_LOW
  } asm_state_t;

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 w_rx_s;
  rx_state_t            r_rx_state;
  logic [TW-1:0]        r_tick_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_byte;
  logic                 r_byte_done;

  asm_state_t           r_asm_state;
  logic [DATA_BITS-1:0] r_inst;
  logic [DATA_BITS-1:0] r_acc_hi;
  logic [CW-1:0]        r_idle_cnt;
  logic                 w_idle_tick;

  assign w_rx_s = r_sync2;
  assign o_busy = (r_asm_state != A_INST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_state    <= RX_IDLE;
      r_tick_cnt    <= '0;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_byte        <= '0;
      r_byte_done   <= 1'b0;
      o_frame_error <= 1'b0;
    end else begin
      r_byte_done   <= 1'b0;
      o_frame_error <= 1'b0;
      if (i_baud_rate) begin
        unique case (r_rx_state)
          RX_IDLE: begin
            if (!w_rx_s) begin
              r_rx_state <= RX_START;
              r_tick_cnt <= '0;
            end
          end
          RX_START: begin
            if (r_tick_cnt == TICK_HALF) begin
              r_tick_cnt <= '0;
              r_bit_cnt  <= '0;
              // a line that is high again mid-start-bit was a glitch
              r_rx_state <= w_rx_s ? RX_IDLE : RX_DATA;
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
          RX_DATA: begin
            if (r_tick_cnt == TICK_LAST) begin
              r_tick_cnt <= '0;
              r_shift    <= {w_rx_s, r_shift[DATA_BITS-1:1]};
              if (r_bit_cnt == BIT_LAST) begin
                r_rx_state <= RX_STOP;
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
          RX_STOP: begin
            if (r_tick_cnt == TICK_LAST) begin
              r_tick_cnt <= '0;
              r_rx_state <= RX_IDLE;
              if (w_rx_s) begin
                r_byte      <= r_shift;
                r_byte_done <= 1'b1;
              end else begin
                o_frame_error <= 1'b1;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
          default: r_rx_state <= RX_IDLE;
        endcase
      end
    end
  end

  assign w_idle_tick = o_busy && i_baud_rate
                    && (r_rx_state == RX_IDLE)
                    && (r_idle_cnt != TO_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_asm_state    <= A_INST;
      r_inst         <= '0;
      r_acc_hi       <= '0;
      r_idle_cnt     <= '0;
      o_inst_count   <= '0;
      o_accumulator  <= '0;
      o_result_valid <= 1'b0;
      o_timeout      <= 1'b0;
    end else begin
      o_result_valid <= 1'b0;
      o_timeout      <= 1'b0;
      if (r_byte_done) begin
        r_idle_cnt <= '0;
        unique case (r_asm_state)
          A_INST: begin
            r_inst      <= r_byte;
            r_asm_state <= A_ACC_HIGH;
          end
          A_ACC_HIGH: begin
            r_acc_hi    <= r_byte;
            r_asm_state <= A_ACC_LOW;
          end
          A_ACC_LOW: begin
            o_inst_count   <= r_inst;
            o_accumulator  <= {r_acc_hi, r_byte};
            o_result_valid <= 1'b1;
            r_asm_state    <= A_INST;
          end
          default: r_asm_state <= A_INST;
        endcase
      end else if (o_frame_error) begin
        // a bad stop bit takes priority over any pending timeout
        r_asm_state <= A_INST;
      end else if (w_idle_tick) begin
        r_idle_cnt <= r_idle_cnt + 1'b1;
        if (r_idle_cnt == TO_LAST) begin
          o_timeout   <= 1'b1;
          r_asm_state <= A_INST;
        end
      end
    end
  end

endmodule

// File: tb/tb_bip_result_receiver.sv
// Directed bench for bip_result_receiver: UART byte driver, a
// frame-level scoreboard model and a per-cycle output compare.
module tb_bip_result_receiver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_baud_rate = 1'b0;
  logic        i_rx = 1'b1;
  logic [7:0]  o_inst_count;
  logic [15:0] o_accumulator;
  logic        o_result_valid;
  logic        o_frame_error;
  logic        o_timeout;
  logic        o_busy;

  bip_result_receiver dut (
    .clk            (clk),
    .rst            (rst),
    .i_baud_rate    (i_baud_rate),
    .i_rx           (i_rx),
    .o_inst_count   (o_inst_count),
    .o_accumulator  (o_accumulator),
    .o_result_valid (o_result_valid),
    .o_frame_error  (o_frame_error),
    .o_timeout      (o_timeout),
    .o_busy         (o_busy)
  );

  always #5 clk = ~clk;

  // one baud tick every 4 clocks
  int bcnt = 0;
  always @(negedge clk) begin
    i_baud_rate = (bcnt == 3);
    bcnt = (bcnt == 3) ? 0 : bcnt + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures < 40)
        $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // frame-level model: expected results queue and held outputs
  typedef struct {
    logic [7:0]  inst;
    logic [15:0] acc;
  } res_t;
  res_t        expq[$];
  logic [7:0]  cur_inst = 8'h00;
  logic [15:0] cur_acc = 16'h0000;
  int          m_pos = 0;
  logic [7:0]  m_inst = 8'h00;
  logic [7:0]  m_hi = 8'h00;

  task automatic mdl_byte(input logic [7:0] b, input bit ok);
    res_t r;
    if (!ok) begin
      m_pos = 0;
    end else if (m_pos == 0) begin
      m_inst = b;
      m_pos = 1;
    end else if (m_pos == 1) begin
      m_hi = b;
      m_pos = 2;
    end else begin
      r.inst = m_inst;
      r.acc = {m_hi, b};
      expq.push_back(r);
      m_pos = 0;
    end
  endtask

  int n_valid = 0;
  int n_ferr = 0;
  int n_to = 0;

  always @(negedge clk) begin
    res_t r;
    if (!rst) begin
      if (o_result_valid) begin
        n_valid++;
        if (expq.size() == 0) begin
          chk("unexpected_valid", 32'd1, 32'd0);
        end else begin
          r = expq.pop_front();
          cur_inst = r.inst;
          cur_acc = r.acc;
        end
      end
      if (o_frame_error) n_ferr++;
      if (o_timeout) n_to++;
      chk("hold_inst", {24'd0, o_inst_count}, {24'd0, cur_inst});
      chk("hold_acc", {16'd0, o_accumulator}, {16'd0, cur_acc});
      chk("exclusive",
          {31'd0, o_result_valid & (o_frame_error | o_timeout)}, 32'd0);
    end
  end

  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk);
      if (i_baud_rate) k++;
    end
  endtask

  task automatic drive(input logic v, input int n);
    @(negedge clk);
    i_rx = v;
    wait_ticks(n);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop);
    mdl_byte(b, stop);
    drive(1'b0, 16);
    for (int i = 0; i < 8; i++) drive(b[i], 16);
    drive(stop, 16);
    drive(1'b1, 4);
    chk("busy_after_byte", {31'd0, o_busy}, {31'd0, m_pos != 0});
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] h,
                            input logic [7:0] l);
    send_byte(a, 1'b1);
    send_byte(h, 1'b1);
    send_byte(l, 1'b1);
    wait_ticks(4);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, f0, t0, k;
    repeat (5) @(negedge clk);
    chk("rst_inst", {24'd0, o_inst_count}, 32'd0);
    chk("rst_acc", {16'd0, o_accumulator}, 32'd0);
    chk("rst_flags", {28'd0, o_result_valid, o_frame_error, o_timeout,
                      o_busy}, 32'd0);
    rst = 1'b0;
    wait_ticks(20);

    v0 = n_valid;
    send_frame(8'h2A, 8'h12, 8'h34);
    chk("f1_pulses", n_valid - v0, 32'd1);
    chk("f1_inst", {24'd0, o_inst_count}, 32'h2A);
    chk("f1_acc", {16'd0, o_accumulator}, 32'h1234);

    v0 = n_valid;
    send_frame(8'h01, 8'hFF, 8'hFE);
    send_frame(8'h02, 8'h80, 8'h00);
    chk("b2b_pulses", n_valid - v0, 32'd2);
    chk("b2b_inst", {24'd0, o_inst_count}, 32'h02);
    chk("b2b_acc", {16'd0, o_accumulator}, 32'h8000);

    v0 = n_valid;
    f0 = n_ferr;
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b0);
    wait_ticks(20);
    chk("ferr_pulses", n_ferr - f0, 32'd1);
    chk("ferr_no_valid", n_valid - v0, 32'd0);
    chk("ferr_busy", {31'd0, o_busy}, 32'd0);
    chk("ferr_acc_kept", {16'd0, o_accumulator}, 32'h8000);
    send_frame(8'hA5, 8'h5A, 8'hC3);
    chk("ferr_next_inst", {24'd0, o_inst_count}, 32'hA5);
    chk("ferr_next_acc", {16'd0, o_accumulator}, 32'h5AC3);

    t0 = n_to;
    v0 = n_valid;
    send_byte(8'h05, 1'b1);
    wait_ticks(4000);
    chk("to_not_early", n_to - t0, 32'd0);
    chk("to_busy_before", {31'd0, o_busy}, 32'd1);
    k = 0;
    while (k < 300 && n_to == t0) begin
      wait_ticks(1);
      k++;
    end
    @(negedge clk);
    m_pos = 0;
    chk("to_pulses", n_to - t0, 32'd1);
    chk("to_busy_after", {31'd0, o_busy}, 32'd0);
    send_frame(8'h07, 8'h00, 8'h09);
    chk("to_valid", n_valid - v0, 32'd1);
    chk("to_next_inst", {24'd0, o_inst_count}, 32'h07);
    chk("to_next_acc", {16'd0, o_accumulator}, 32'h0009);

    v0 = n_valid;
    f0 = n_ferr;
    t0 = n_to;
    drive(1'b0, 3);
    drive(1'b1, 40);
    chk("glitch_valid", n_valid - v0, 32'd0);
    chk("glitch_ferr", n_ferr - f0, 32'd0);
    chk("glitch_to", n_to - t0, 32'd0);
    chk("glitch_busy", {31'd0, o_busy}, 32'd0);

    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    m_pos = 0;
    expq.delete();
    cur_inst = 8'h00;
    cur_acc = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst2_inst", {24'd0, o_inst_count}, 32'd0);
    chk("rst2_acc", {16'd0, o_accumulator}, 32'd0);
    chk("rst2_busy", {31'd0, o_busy}, 32'd0);
    rst = 1'b0;
    wait_ticks(4);
    v0 = n_valid;
    send_frame(8'h11, 8'hAB, 8'hCD);
    chk("rst2_valid", n_valid - v0, 32'd1);
    chk("rst2_next_inst", {24'd0, o_inst_count}, 32'h11);
    chk("rst2_next_acc", {16'd0, o_accumulator}, 32'hABCD);

    wait_ticks(10);
    chk("queue_drained", expq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
